usb2_ep_in_arbiter: RTL and testbench
=====================================

// Module: usb2_ep_in_arbiter
// PURPOSE
//  Multi-channel IN-endpoint packetiser/arbiter on the ext_clk side of the USB 2.0 core.
//  - Merges NUM_CH byte streams (valid/ready/last) onto the single external buffer interface.
//  - Cuts each stream into packets of at most MAX_PKT bytes; adds ZLPs on exact-multiple ends.
//  - Selects channels by round-robin and reports the endpoint number of each committed packet.
// PARAMETERS
//  NUM_CH   4    number of input channels (1..8)
//  ADDR_W   9    buffer address width; MAX_PKT <= 2**ADDR_W
//  MAX_PKT  512  maximum packet payload in bytes (>=1)
//  EP_BASE  1    endpoint number of channel 0; channel i -> EP_BASE+i (must be <=15)
//  ZLP_EN   1    1: append zero-length packet when a transfer ends on a MAX_PKT boundary
// PORTS
//  ext_clk            in   1          sole clock
//  reset_n            in   1          synchronous, active-low reset
//  ch_data            in   NUM_CH*8   channel i byte at [8i+7:8i]
//  ch_valid           in   NUM_CH     byte present on channel i
//  ch_last            in   NUM_CH     byte is final byte of a transfer
//  ch_ready           out  NUM_CH     byte accepted when valid&ready
//  buf_in_addr        out  ADDR_W     buffer write address
//  buf_in_data        out  8          buffer write data
//  buf_in_wren        out  1          buffer write strobe
//  buf_in_ready       in   1          buffer free for a new packet
//  buf_in_commit      out  1          packet commit request (level)
//  buf_in_commit_len  out  ADDR_W+1   committed byte count (0..MAX_PKT)
//  buf_in_commit_ack  in   1          commit acknowledge (4-phase)
//  buf_in_endp        out  4          endpoint of packet being filled/committed
//  stat_busy          out  1          state != IDLE
//  stat_pkt_count     out  16         packets committed, wraps at 2**16
// BEHAVIOUR
//  - Reset: all outputs 0. State IDLE, rr_ptr=0, zlp_pending=0, byte count=0.
//  - States:
//    IDLE -> GRANT: when buf_in_ready=1 and buf_in_commit_ack=0.
//      Candidates are channels with ch_valid|zlp_pending. Pick the first candidate at or
//      after rr_ptr (wrapping). No candidate: remain in IDLE.
//    GRANT: register grant g. buf_in_endp <= EP_BASE+g. count <= 0.
//      If zlp_pending[g]: clear it and go to COMMIT with len 0. Otherwise go to FILL.
//    FILL: ch_ready = onehot(g), combinational from state; all other ready bits are 0.
//      Each accepted byte: next cycle buf_in_wren=1, addr=count, data=byte; count += 1.
//      Ends on an accepted byte with last=1, or on the byte that makes count==MAX_PKT.
//      The ending edge moves state to COMMIT, so ch_ready is 0 on the following cycle.
//      A byte with last=1 that also makes count==MAX_PKT sets zlp_pending[g] if ZLP_EN.
//      A valid gap mid-packet holds FILL indefinitely (no timeout).
//    COMMIT: buf_in_commit=1, buf_in_commit_len=count, held stable until buf_in_commit_ack=1.
//      That edge moves to RELEASE: commit=0, stat_pkt_count += 1.
//    RELEASE: wait for buf_in_commit_ack=0, then go to IDLE with rr_ptr <= (g+1) mod NUM_CH.
//  - Latency: first byte accepted 2 cycles after the IDLE decision. Write lags acceptance by 1 cycle.
//    Commit is asserted the cycle after the last write.
//  - buf_in_endp is held from GRANT until RELEASE exits.
//  - buf_in_ready is sampled only in IDLE; deassertion during FILL/COMMIT is ignored.
//  - A stale commit_ack=1 in IDLE blocks arbitration until it drops.
//  - Reset mid-packet: commit drops the next cycle. The partial packet is discarded; the bench
//    must not expect a commit.
//  - Width: count is ADDR_W+1 bits and never exceeds MAX_PKT. The address is count[ADDR_W-1:0].
// TESTING
//  - Ch0 sends 3 bytes 0xA1,A2,A3(last) -> wren at addr 0,1,2; commit len=3; endp=EP_BASE;
//    pkt_count=1.
//  - Ch0 streams 1030 bytes with last on the final byte, MAX_PKT=512 -> commits of len
//    512, 512, 6; addresses restart at 0 each packet.
//  - Ch1 sends exactly 512 bytes with last, ZLP_EN=1 -> commit 512, then commit len=0 on
//    endp EP_BASE+1. With ZLP_EN=0 -> no ZLP.
//  - All 4 channels are continuously valid with 1-byte packets -> grant order 0,1,2,3,0.
//    buf_in_endp is 1,2,3,4,1.
//  - commit_ack held high for 5 cycles -> no new grant until it falls.
//    buf_in_ready=0 in IDLE -> ch_ready stays 0.
//  - reset_n=0 for 1 cycle mid-FILL on ch2 -> all outputs 0 next cycle.
//    After release, ch2 restarts a fresh packet at addr 0.

Source files
------------

// File: rtl/usb2_ep_in_arbiter.sv
// Round-robin IN-endpoint packetiser: merges NUM_CH byte streams into MAX_PKT-sized
// packets on the external buffer, appending zero-length packets on exact-multiple transfers.
module usb2_ep_in_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 9,
  parameter int MAX_PKT = 512,
  parameter int EP_BASE = 1,
  parameter int ZLP_EN  = 1
) (
  input  logic                ext_clk,
  input  logic                reset_n,
  input  logic [NUM_CH*8-1:0] ch_data,
  input  logic [NUM_CH-1:0]   ch_valid,
  input  logic [NUM_CH-1:0]   ch_last,
  output logic [NUM_CH-1:0]   ch_ready,
  output logic [ADDR_W-1:0]   buf_in_addr,
  output logic [7:0]          buf_in_data,
  output logic                buf_in_wren,
  input  logic                buf_in_ready,
  output logic                buf_in_commit,
  output logic [ADDR_W:0]     buf_in_commit_len,
  input  logic                buf_in_commit_ack,
  output logic [3:0]          buf_in_endp,
  output logic                stat_busy,
  output logic [15:0]         stat_pkt_count
);

  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MAX_PKT);
  localparam logic [3:0]      EP0     = 4'(EP_BASE);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    FILL    = 3'd2,
    COMMIT  = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   rr_ptr;
  logic [NUM_CH-1:0] zlp_pending;
  logic [ADDR_W:0]   count;

  logic [NUM_CH-1:0] cand;
  logic              cand_found;
  logic [CH_W-1:0]   cand_pick;
  logic [CH_W-1:0]   cand_idx;
  logic [7:0]        sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic [ADDR_W:0]   count_inc;
  logic              pkt_full;
  logic [CH_W-1:0]   rr_next;

  // Scan downward from the farthest offset so the nearest candidate at/after rr_ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cand       = ch_valid | zlp_pending;
    cand_found = 1'b0;
    cand_pick  = '0;
    cand_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand_idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (cand[cand_idx]) begin
        cand_found = 1'b1;
        cand_pick  = cand_idx;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant == CH_W'(k)) begin
        sel_data  = ch_data[8*k +: 8];
        sel_valid = ch_valid[k];
        sel_last  = ch_last[k];
      end
    end
  end

  assign count_inc = count + (ADDR_W + 1)'(1);
  assign pkt_full  = (count_inc == MAX_LEN);
  assign rr_next   = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);

  // Ready is decoded straight from the registered state so it drops the cycle FILL ends.
  assign ch_ready  = (state == FILL) ? (NUM_CH'(1) << grant) : '0;
  assign stat_busy = (state != IDLE);

  always_ff @(posedge ext_clk) begin
    // NOTE: non-blocking assignments so every branch reads pre-edge state, not partial updates.
    if (!reset_n) begin
      state             <= IDLE;
      grant             <= '0;
      rr_ptr            <= '0;
      zlp_pending       <= '0;
      count             <= '0;
      buf_in_addr       <= '0;
      buf_in_data       <= '0;
      buf_in_wren       <= 1'b0;
      buf_in_commit     <= 1'b0;
      buf_in_commit_len <= '0;
      buf_in_endp       <= '0;
      stat_pkt_count    <= '0;
    end else begin
      buf_in_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (buf_in_ready && !buf_in_commit_ack && cand_found) begin
            grant <= cand_pick;
            state <= GRANT;
          end
        end

        GRANT: begin
          buf_in_endp <= EP0 + 4'(grant);
          count       <= '0;
          if (zlp_pending[grant]) begin
            zlp_pending[grant] <= 1'b0;
            state              <= COMMIT;
          end else begin
            state <= FILL;
          end
        end

        FILL: begin
          if (sel_valid) begin
            buf_in_wren <= 1'b1;
            buf_in_addr <= count[ADDR_W-1:0];
            buf_in_data <= sel_data;
            count       <= count_inc;
            if (sel_last || pkt_full) begin
              state <= COMMIT;
              // A transfer ending exactly on a packet boundary still owes the host a ZLP.
              if (ZLP_EN != 0 && sel_last && pkt_full) zlp_pending[grant] <= 1'b1;
            end
          end
        end

        // First COMMIT cycle carries the final write; the request rises one cycle later.
        COMMIT: begin
          if (!buf_in_commit) begin
            buf_in_commit     <= 1'b1;
            buf_in_commit_len <= count;
          end else if (buf_in_commit_ack) begin
            buf_in_commit  <= 1'b0;
            stat_pkt_count <= stat_pkt_count + 16'd1;
            state          <= RELEASE;
          end
        end

        RELEASE: begin
          if (!buf_in_commit_ack) begin
            rr_ptr <= rr_next;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb2_ep_in_arbiter.sv
// Scoreboard bench for usb2_ep_in_arbiter: per-channel transfers are split into expected
// packets by a length model; a monitor checks every committed packet against that model.
module tb_usb2_ep_in_arbiter;

  localparam int NUM_CH  = 4;
  localparam int ADDR_W  = 9;
  localparam int MAX_PKT = 512;
  localparam int EP_BASE = 1;
  localparam int ZLP_EN  = 1;

  logic                ext_clk = 1'b0;
  logic                reset_n;
  logic [NUM_CH*8-1:0] ch_data;
  logic [NUM_CH-1:0]   ch_valid;
  logic [NUM_CH-1:0]   ch_last;
  logic [NUM_CH-1:0]   ch_ready;
  logic [ADDR_W-1:0]   buf_in_addr;
  logic [7:0]          buf_in_data;
  logic                buf_in_wren;
  logic                buf_in_ready;
  logic                buf_in_commit;
  logic [ADDR_W:0]     buf_in_commit_len;
  logic                buf_in_commit_ack;
  logic [3:0]          buf_in_endp;
  logic                stat_busy;
  logic [15:0]         stat_pkt_count;

  usb2_ep_in_arbiter #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .MAX_PKT(MAX_PKT),
    .EP_BASE(EP_BASE),
    .ZLP_EN (ZLP_EN)
  ) dut (
    .ext_clk          (ext_clk),
    .reset_n          (reset_n),
    .ch_data          (ch_data),
    .ch_valid         (ch_valid),
    .ch_last          (ch_last),
    .ch_ready         (ch_ready),
    .buf_in_addr      (buf_in_addr),
    .buf_in_data      (buf_in_data),
    .buf_in_wren      (buf_in_wren),
    .buf_in_ready     (buf_in_ready),
    .buf_in_commit    (buf_in_commit),
    .buf_in_commit_len(buf_in_commit_len),
    .buf_in_commit_ack(buf_in_commit_ack),
    .buf_in_endp      (buf_in_endp),
    .stat_busy        (stat_busy),
    .stat_pkt_count   (stat_pkt_count)
  );

  always #5 ext_clk = ~ext_clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      txq       [NUM_CH][$];
  logic [7:0] exp_bytes [NUM_CH][$];
  int         exp_len   [NUM_CH][$];
  int         obs_endp  [$];
  logic [7:0] pkt_mem   [MAX_PKT];

  int checks = 0;
  int errors = 0;
  int density = 100;
  int ready_pct = 100;
  bit ready_en = 1'b0;
  bit force_ack = 1'b0;
  int wr_idx = 0;
  int pkts_seen = 0;
  int cyc = 0;
  int last_wr_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Reference model: a transfer of n bytes becomes floor(n/MAX) full packets plus the
  // remainder, or a ZLP when the transfer is a non-zero exact multiple of MAX_PKT.
  task automatic push_xfer(input int ch, input int n, input logic [7:0] base, input bit rnd);
    logic [7:0] d;
    beat_t      bt;
    for (int i = 0; i < n; i++) begin
      d    = rnd ? 8'($urandom) : base + 8'(i);
      bt.d = d;
      bt.l = (i == n - 1);
      txq[ch].push_back(bt);
      exp_bytes[ch].push_back(d);
    end
    for (int p = 0; p < n / MAX_PKT; p++) exp_len[ch].push_back(MAX_PKT);
    if (n % MAX_PKT != 0) exp_len[ch].push_back(n % MAX_PKT);
    else if (ZLP_EN != 0) exp_len[ch].push_back(0);
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NUM_CH; k++)
      if (txq[k].size() != 0 || exp_len[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name);
    for (int t = 0; t < 30000; t++) begin
      @(negedge ext_clk);
      if (all_empty() && !stat_busy && !buf_in_commit_ack) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: transfers still pending after 30000 cycles", name);
    finish_sim();
  endtask

  task automatic wait_commits(input int n);
    for (int t = 0; t < 2000; t++) begin
      @(negedge ext_clk);
      if (obs_endp.size() >= n) return;
    end
    checks++;
    errors++;
    $display("FAIL commit_wait_timeout: saw %0d commits, required %0d", obs_endp.size(), n);
    finish_sim();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_wren"},   buf_in_wren, 0);
    check({name, "_commit"}, buf_in_commit, 0);
    check({name, "_len"},    buf_in_commit_len, 0);
    check({name, "_endp"},   buf_in_endp, 0);
    check({name, "_busy"},   stat_busy, 0);
    check({name, "_pktcnt"}, stat_pkt_count, 0);
    check({name, "_ready"},  ch_ready, 0);
    check({name, "_addr"},   buf_in_addr, 0);
    check({name, "_data"},   buf_in_data, 0);
  endtask

  // Stimulus driver and 4-phase ack responder: samples at negedge, drives 1 after posedge.
  initial begin : driver
    bit acc [NUM_CH];
    bit commit_s;
    bit hold;
    int ack_dly;
    ch_valid          = '0;
    ch_data           = '0;
    ch_last           = '0;
    buf_in_ready      = 1'b0;
    buf_in_commit_ack = 1'b0;
    ack_dly           = -1;
    forever begin
      @(negedge ext_clk);
      for (int k = 0; k < NUM_CH; k++) acc[k] = ch_valid[k] && ch_ready[k];
      commit_s = buf_in_commit;
      @(posedge ext_clk);
      #1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (acc[k] && txq[k].size() > 0) void'(txq[k].pop_front());
        hold = ch_valid[k] && !acc[k];
        if (txq[k].size() == 0) ch_valid[k] = 1'b0;
        else if (!hold) ch_valid[k] = ($urandom_range(0, 99) < density);
        if (txq[k].size() > 0) begin
          ch_data[8*k +: 8] = txq[k][0].d;
          ch_last[k]        = txq[k][0].l;
        end else begin
          ch_data[8*k +: 8] = 8'h00;
          ch_last[k]        = 1'b0;
        end
      end
      buf_in_ready = ready_en && ($urandom_range(0, 99) < ready_pct);
      if (force_ack) begin
        buf_in_commit_ack = 1'b1;
      end else if (commit_s) begin
        if (!buf_in_commit_ack) begin
          if (ack_dly < 0) ack_dly = $urandom_range(0, 3);
          if (ack_dly == 0) begin
            buf_in_commit_ack = 1'b1;
            ack_dly           = -1;
          end else begin
            ack_dly--;
          end
        end
      end else begin
        buf_in_commit_ack = 1'b0;
      end
    end
  end

  // Monitor: collects written bytes, pops the expected packet on each commit rise.
  initial begin : monitor
    bit         commit_q;
    int         ch;
    int         el;
    int         held_len;
    int         held_endp;
    logic [7:0] b;
    logic [7:0] a;
    commit_q = 1'b0;
    forever begin
      @(negedge ext_clk);
      cyc++;
      if (!reset_n) begin
        wr_idx    = 0;
        pkts_seen = 0;
        commit_q  = 1'b0;
      end else begin
        if (buf_in_wren) begin
          check("write_addr", buf_in_addr, wr_idx);
          if (wr_idx < MAX_PKT) pkt_mem[wr_idx] = buf_in_data;
          else check("packet_overflow", wr_idx, MAX_PKT - 1);
          wr_idx++;
          last_wr_cyc = cyc;
        end
        if (buf_in_commit && !commit_q) begin
          ch        = int'(buf_in_endp) - EP_BASE;
          held_len  = int'(buf_in_commit_len);
          held_endp = int'(buf_in_endp);
          obs_endp.push_back(held_endp);
          check("commit_busy", stat_busy, 1);
          check("pkt_count", stat_pkt_count, pkts_seen);
          if (ch < 0 || ch >= NUM_CH) begin
            checks++;
            errors++;
            $display("FAIL commit_endp: got endpoint %0d, required %0d..%0d",
                     held_endp, EP_BASE, EP_BASE + NUM_CH - 1);
          end else if (exp_len[ch].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: got len %0d on endp %0d, required no packet",
                     held_len, held_endp);
          end else begin
            el = exp_len[ch].pop_front();
            check("commit_len", held_len, el);
            check("write_count", wr_idx, el);
            if (el > 0) check("commit_latency", cyc, last_wr_cyc + 1);
            for (int i = 0; i < el; i++) begin
              b = (exp_bytes[ch].size() > 0) ? exp_bytes[ch].pop_front() : 8'h00;
              a = (i < wr_idx && i < MAX_PKT) ? pkt_mem[i] : 8'hxx;
              check("pkt_byte", a, b);
            end
          end
          pkts_seen++;
          wr_idx = 0;
        end else if (buf_in_commit && commit_q) begin
          check("commit_hold_len", buf_in_commit_len, held_len);
          check("commit_hold_endp", buf_in_endp, held_endp);
        end
        commit_q = buf_in_commit;
      end
    end
  end

  initial begin : watchdog
    #900000;
    errors++;
    $display("FAIL watchdog: simulation exceeded 90000 cycles");
    finish_sim();
  end

  initial begin : sequencer
    int ch;
    int n;
    int r;
    bit fill_seen;
    reset_n = 1'b0;
    repeat (3) @(posedge ext_clk);
    @(negedge ext_clk);
    check_all_zero("reset");
    @(posedge ext_clk);
    #2 reset_n = 1'b1;

    // Round-robin order with every channel valid, while buf_in_ready holds arbitration off.
    density  = 100;
    ready_en = 1'b0;
    push_xfer(0, 1, 8'h10, 1'b0);
    push_xfer(0, 1, 8'h14, 1'b0);
    push_xfer(1, 1, 8'h11, 1'b0);
    push_xfer(2, 1, 8'h12, 1'b0);
    push_xfer(3, 1, 8'h13, 1'b0);
    repeat (5) begin
      @(negedge ext_clk);
      check("no_buf_ready_ch_ready", ch_ready, 0);
      check("no_buf_ready_busy", stat_busy, 0);
    end
    obs_endp.delete();
    ready_en = 1'b1;
    wait_commits(5);
    for (int i = 0; i < 5; i++) check("grant_order_endp", obs_endp[i], EP_BASE + (i % NUM_CH));
    wait_drain("rr");
    check("pkt_total_rr", stat_pkt_count, 5);

    push_xfer(0, 3, 8'hA1, 1'b0);
    wait_drain("three_byte");
    check("pkt_total_three", stat_pkt_count, 6);
    check("three_byte_endp", obs_endp[obs_endp.size() - 1], EP_BASE);

    push_xfer(0, 1030, 8'h00, 1'b1);
    wait_drain("long");
    check("pkt_total_long", stat_pkt_count, 9);

    push_xfer(1, 512, 8'h00, 1'b1);
    wait_drain("zlp");
    check("pkt_total_zlp", stat_pkt_count, 11);
    check("zlp_endp", obs_endp[obs_endp.size() - 1], EP_BASE + 1);

    // A stale ack in IDLE must block arbitration until it falls.
    force_ack = 1'b1;
    @(posedge ext_clk);
    #2;
    push_xfer(3, 2, 8'h30, 1'b0);
    repeat (5) begin
      @(negedge ext_clk);
      check("stale_ack_ch_ready", ch_ready, 0);
      check("stale_ack_busy", stat_busy, 0);
    end
    force_ack = 1'b0;
    wait_drain("stale_ack");
    check("pkt_total_stale", stat_pkt_count, 12);

    // One-cycle reset in the middle of a ch2 packet discards the partial packet.
    push_xfer(2, 10, 8'h50, 1'b0);
    fill_seen = 1'b0;
    for (int t = 0; t < 200 && !fill_seen; t++) begin
      @(negedge ext_clk);
      if (wr_idx >= 3) fill_seen = 1'b1;
    end
    check("mid_fill_reached", fill_seen, 1);
    @(posedge ext_clk);
    #2 reset_n = 1'b0;
    txq[2].delete();
    exp_bytes[2].delete();
    exp_len[2].delete();
    @(posedge ext_clk);
    #2 reset_n = 1'b1;
    @(negedge ext_clk);
    check_all_zero("mid_reset");
    push_xfer(2, 4, 8'h60, 1'b0);
    wait_drain("after_reset");
    check("pkt_total_after_reset", stat_pkt_count, 1);
    check("after_reset_endp", obs_endp[obs_endp.size() - 1], EP_BASE + 2);

    // Randomised mixed traffic, including packet-boundary lengths.
    density   = 60;
    ready_pct = 85;
    for (int i = 0; i < 30; i++) begin
      ch = $urandom_range(0, NUM_CH - 1);
      r  = $urandom_range(0, 9);
      if (r < 6)       n = $urandom_range(1, 16);
      else if (r == 6) n = MAX_PKT;
      else if (r == 7) n = ($urandom_range(0, 1) != 0) ? MAX_PKT + 1 : MAX_PKT - 1;
      else if (r == 8) n = $urandom_range(2, 4);
      else             n = $urandom_range(17, 100);
      push_xfer(ch, n, 8'h00, 1'b1);
    end
    wait_drain("random");
    for (int k = 0; k < NUM_CH; k++) check("leftover_bytes", exp_bytes[k].size(), 0);
    finish_sim();
  end

endmodule
